keccak_round_scheduler: RTL and testbench
=========================================

// Module: keccak_round_scheduler
// PURPOSE
//  Top-level sequencer for the Keccak-f permutation datapath. Runs NUM_ROUNDS rounds; each round fires the five
//  step units (0 theta, 1 rho, 2 pi, 3 chi, 4 iota/AddRc) in order, over their start/ready handshake.
//  Drives the round index to the iota round-constant ROM and the ping-pong state-bank select.
//  Sits between the permutation wrapper (start/done) and the per-step slice controllers.
// PARAMETERS
//  NUM_ROUNDS  24    rounds per permutation
//  NUM_STEPS   5     step units per round; bit k of every step bus = unit k
//  ROUND_W     5     width of roundIdx, >= clog2(NUM_ROUNDS)
//  TIMEOUT     1023  max cycles in one wait state before error; counter width clog2(TIMEOUT+1)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous reset, active-low (rst==0 resets on the clock edge)
//  start      in   1          permutation request, sampled only in IDLE
//  stepMask   in   NUM_STEPS  1 = run unit k; latched at start acceptance; 0 = skip (bring-up/debug)
//  stepReady  in   NUM_STEPS  ready from unit k: 1 idle, 0 busy
//  stepStart  out  NUM_STEPS  one-hot, one-cycle start pulse to unit k
//  roundIdx   out  ROUND_W    current round, to iota RC ROM
//  bankSel    out  1          state bank read by the active unit; the unit writes ~bankSel
//  ready      out  1          1 only in IDLE
//  done       out  1          one-cycle pulse: permutation finished OK
//  error      out  1          sticky timeout flag; cleared when the next start is accepted
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE, roundIdx=0, stepIdx=0, bankSel=0, error=0, latched mask=0.
//    Outputs Moore-decoded from state: ready=1, stepStart=0, done=0. Reset at any state aborts at once.
//  - IDLE: ready=1. start=1 -> LOAD. start outside IDLE is ignored.
//  - LOAD: latch stepMask; roundIdx=0, stepIdx=0, bankSel=0, error=0, wdog=0 -> SEL.
//  - SEL: mask[stepIdx]=1 -> ISSUE, else -> ADV (a skipped step keeps bankSel).
//  - ISSUE: stepStart[stepIdx]=1 for exactly this cycle; wdog=0 -> WAITB.
//  - WAITB: stepReady[stepIdx]==0 -> WAITD, wdog=0. Otherwise wdog++.
//  - WAITD: stepReady[stepIdx]==1 -> ADV, and bankSel toggles on this exit. Otherwise wdog++.
//  - Timeout: in WAITB/WAITD, wdog==TIMEOUT and the exit condition is false -> ERR.
//  - ERR: error=1 (sticky), no done pulse -> IDLE. Units must not be started again until the next start.
//  - ADV: stepIdx<NUM_STEPS-1 -> stepIdx++, SEL.
//    Otherwise stepIdx=0; roundIdx==NUM_ROUNDS-1 -> FIN, else roundIdx++, SEL.
//  - FIN: done=1 for one cycle -> IDLE. roundIdx holds NUM_ROUNDS-1 until the next LOAD.
//  - Only stepReady[stepIdx] is observed; the other ready bits are don't-care.
//  - A unit whose ready never drops is caught by the WAITB timeout. It is never silently passed.
//  - Latency: LOAD(1) + sum over steps [SEL + ADV + (run ? ISSUE + WAITB + WAITD : 0)] + FIN(1).
//    An all-zero mask gives 2 + 2*NUM_STEPS*NUM_ROUNDS cycles from the cycle after start to the done cycle.
//  - Arithmetic: roundIdx and stepIdx never wrap past their terminal value; wdog saturates at TIMEOUT.
// STRUCTURE
//  - keccak_pkg: NUM_STEPS, step index constants (STEP_THETA..STEP_IOTA), scheduler state encoding
//    (IDLE, LOAD, SEL, ISSUE, WAITB, WAITD, ADV, FIN, ERR), default NUM_ROUNDS.
//  - Split into a next-state/output combinational block and a state register, as for the other controllers.
//  - One sub-module, mod_counter (en/clr/co, parameterised modulus), instanced twice: stepIdx and roundIdx.
//    Its co output drives the ADV decisions.
// TESTING
//  1. Reset: hold rst=0 for 2 clks with start=1 -> ready=1, done=0, stepStart=0, roundIdx=0, bankSel=0.
//  2. NUM_ROUNDS=2, mask=0, start 1 cycle -> no stepStart ever; done pulses 22 cycles after the
//     start-accepted edge; ready=1 the next cycle.
//  3. Full run, mask=5'h1F, model units busy 3 cycles ->
//     - stepStart sequence 01,02,04,08,10 repeated 24 times;
//     - roundIdx 0..23; bankSel toggles 120 times, ending 0;
//     - exactly one done pulse.
//  4. mask=5'b10001 -> only theta and iota pulse each round; bankSel toggles twice per round.
//  5. TIMEOUT=15, rho unit holds ready=1 -> after ISSUE, ERR within 16 cycles; error=1 with no done.
//     Next start clears error and the run completes.
//  6. rst=0 mid-WAITD in round 7 -> next cycle IDLE, roundIdx=0, bankSel=0, stepStart=0.
//     A fresh start runs normally.

Source files
------------

// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared constants and scheduler state encoding for the Keccak-f sequencer
package keccak_pkg;
    localparam int NUM_STEPS      = 5;
    localparam int STEP_W         = $clog2(NUM_STEPS);
    localparam int DEF_NUM_ROUNDS = 24;

    localparam int STEP_THETA = 0;
    localparam int STEP_RHO   = 1;
    localparam int STEP_PI    = 2;
    localparam int STEP_CHI   = 3;
    localparam int STEP_IOTA  = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEL,
        ST_ISSUE,
        ST_WAITB,
        ST_WAITD,
        ST_ADV,
        ST_FIN,
        ST_ERR
    } sched_state_t;
endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD up counter with clear, enable and terminal-count flag
module mod_counter #(
    parameter int MOD = 5,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         co
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign co = (q == LAST);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            q <= '0;
        end else if (en) begin
            q <= co ? '0 : q + 1'b1;
        end
    end
endmodule

// File: rtl/keccak_round_scheduler.sv
// rtl/keccak_round_scheduler.sv - round/step sequencer driving the five Keccak step units
module keccak_round_scheduler
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int ROUND_W    = 5,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_STEPS-1:0] stepMask,
    input  logic [NUM_STEPS-1:0] stepReady,
    output logic [NUM_STEPS-1:0] stepStart,
    output logic [ROUND_W-1:0]   roundIdx,
    output logic                 bankSel,
    output logic                 ready,
    output logic                 done,
    output logic                 error
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    sched_state_t         state, state_n;
    logic [NUM_STEPS-1:0] mask, mask_n;
    logic [WD_W-1:0]      wdog, wdog_n;
    logic                 bank_n, error_n;
    logic [STEP_W-1:0]    step_idx;
    logic                 step_co, round_co;
    logic                 cnt_clr, step_en, round_en;
    logic                 cur_ready;

    // Step counter wraps to 0 after the last step; round counter is held at its terminal value.
    assign cnt_clr  = (state == ST_LOAD);
    assign step_en  = (state == ST_ADV);
    assign round_en = (state == ST_ADV) && step_co && !round_co;

    mod_counter #(.MOD(NUM_STEPS), .W(STEP_W)) u_step_cnt (
        .clk    (clk),
        .resetn (rst),
        .clr    (cnt_clr),
        .en     (step_en),
        .q      (step_idx),
        .co     (step_co)
    );

    mod_counter #(.MOD(NUM_ROUNDS), .W(ROUND_W)) u_round_cnt (
        .clk    (clk),
        .resetn (rst),
        .clr    (cnt_clr),
        .en     (round_en),
        .q      (roundIdx),
        .co     (round_co)
    );

    assign cur_ready = stepReady[step_idx];

    assign ready     = (state == ST_IDLE);
    assign done      = (state == ST_FIN);
    assign stepStart = (state == ST_ISSUE) ? (NUM_STEPS'(1) << step_idx) : '0;

    always_comb begin
        state_n = state;
        mask_n  = mask;
        wdog_n  = wdog;
        bank_n  = bankSel;
        error_n = error;
        case (state)
            ST_IDLE:  if (start) state_n = ST_LOAD;
            ST_LOAD: begin
                mask_n  = stepMask;
                bank_n  = 1'b0;
                error_n = 1'b0;
                wdog_n  = '0;
                state_n = ST_SEL;
            end
            ST_SEL:   state_n = mask[step_idx] ? ST_ISSUE : ST_ADV;
            ST_ISSUE: begin
                wdog_n  = '0;
                state_n = ST_WAITB;
            end
            ST_WAITB: begin
                if (!cur_ready) begin
                    state_n = ST_WAITD;
                    wdog_n  = '0;
                end else if (wdog == WD_MAX) begin
                    state_n = ST_ERR;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            ST_WAITD: begin
                if (cur_ready) begin
                    state_n = ST_ADV;
                    bank_n  = ~bankSel;
                end else if (wdog == WD_MAX) begin
                    state_n = ST_ERR;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            ST_ADV:   state_n = (step_co && round_co) ? ST_FIN : ST_SEL;
            ST_FIN:   state_n = ST_IDLE;
            ST_ERR: begin
                error_n = 1'b1;
                state_n = ST_IDLE;
            end
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            mask    <= '0;
            wdog    <= '0;
            bankSel <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            mask    <= mask_n;
            wdog    <= wdog_n;
            bankSel <= bank_n;
            error   <= error_n;
        end
    end
endmodule

// File: tb/tb_keccak_round_scheduler.sv
// tb/tb_keccak_round_scheduler.sv - directed self-checking bench for keccak_round_scheduler
module tb_keccak_round_scheduler;
    import keccak_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [4:0] mask_a = '0, mask_b = '0;
    logic [4:0] rdy_in_a = 5'h1F, rdy_in_b = 5'h1F;
    logic [4:0] ss_a, ss_b, ri_a, ri_b;
    logic       bs_a, bs_b, rdy_a, rdy_b, done_a, done_b, err_a, err_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    keccak_round_scheduler #(.NUM_ROUNDS(24), .ROUND_W(5), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .start(start_a), .stepMask(mask_a), .stepReady(rdy_in_a),
        .stepStart(ss_a), .roundIdx(ri_a), .bankSel(bs_a), .ready(rdy_a), .done(done_a), .error(err_a)
    );

    keccak_round_scheduler #(.NUM_ROUNDS(2), .ROUND_W(5), .TIMEOUT(15)) dut_small (
        .clk(clk), .rst(rst), .start(start_b), .stepMask(mask_b), .stepReady(rdy_in_b),
        .stepStart(ss_b), .roundIdx(ri_b), .bankSel(bs_b), .ready(rdy_b), .done(done_b), .error(err_b)
    );

    // Step unit models: busy for 3 cycles after a start pulse; stuck_b forces ready high.
    int         busy_a[5] = '{default: 0};
    int         busy_b[5] = '{default: 0};
    logic [4:0] stuck_b = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (busy_a[k] > 0) busy_a[k] = busy_a[k] - 1;
            if (ss_a[k] === 1'b1) busy_a[k] = 3;
            if (busy_b[k] > 0) busy_b[k] = busy_b[k] - 1;
            if (ss_b[k] === 1'b1) busy_b[k] = 3;
            rdy_in_a[k] = (busy_a[k] == 0);
            rdy_in_b[k] = stuck_b[k] || (busy_b[k] == 0);
        end
    end

    logic [9:0] log_q[$];
    int   pulses_b = 0, toggles_a = 0, dones_a = 0, dones_b = 0;
    logic bs_prev = 1'b0;

    always @(negedge clk) begin
        if (ss_a !== 5'd0) log_q.push_back({ri_a, ss_a});
        if (ss_b !== 5'd0) pulses_b++;
        if (bs_a !== bs_prev) toggles_a++;
        bs_prev = bs_a;
        if (done_a === 1'b1) dones_a++;
        if (done_b === 1'b1) dones_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit b, input logic [4:0] m, input int bound, output int n);
        @(negedge clk);
        if (b) begin mask_b = m; start_b = 1'b1; end
        else   begin mask_a = m; start_a = 1'b1; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if ((b ? done_b : done_a) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_seq(input string tag, input logic [4:0] m);
        int bad = 0;
        int idx = 0;
        logic [9:0] exp;
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 5; k++) begin
                if (m[k]) begin
                    exp = {5'(r), 5'(1 << k)};
                    if (idx >= log_q.size() || log_q[idx] !== exp) bad++;
                    idx++;
                end
            end
        end
        check({tag, "_len"}, log_q.size(), idx);
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        int n, t0, d0, p0, found;

        // Reset with start held high on both instances
        rst = 1'b0; start_a = 1'b1; start_b = 1'b1; mask_a = 5'h1F; mask_b = 5'h1F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy_a, 1);
        check("rst_done", done_a, 0);
        check("rst_stepstart", ss_a, 0);
        check("rst_roundidx", ri_a, 0);
        check("rst_banksel", bs_a, 0);
        check("rst_error", err_a, 0);
        check("rst_ready_small", rdy_b, 1);
        start_a = 1'b0; start_b = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);

        // Two rounds, all steps skipped
        run(1'b1, 5'h00, 100, n);
        check("skip_latency", n, 22);
        check("skip_roundidx_hold", ri_b, 1);
        @(negedge clk);
        check("skip_ready_after", rdy_b, 1);
        check("skip_done_single", done_b, 0);
        check("skip_no_pulses", pulses_b, 0);

        // Full 24-round run, all steps
        log_q.delete(); t0 = toggles_a; d0 = dones_a;
        run(1'b0, 5'h1F, 2000, n);
        check("full_latency", n, 722);
        check("full_roundidx_end", ri_a, 23);
        repeat (3) @(negedge clk);
        check("full_toggles", toggles_a - t0, 120);
        check("full_bank_end", bs_a, 0);
        check("full_done_count", dones_a - d0, 1);
        check("full_ready", rdy_a, 1);
        check_seq("full_seq", 5'h1F);

        // Theta and iota only
        log_q.delete(); t0 = toggles_a;
        run(1'b0, 5'b10001, 2000, n);
        check("partial_latency", n, 434);
        repeat (3) @(negedge clk);
        check("partial_toggles", toggles_a - t0, 48);
        check_seq("partial_seq", 5'b10001);

        // Rho unit never drops ready -> timeout on the small instance
        stuck_b = 5'(1 << STEP_RHO); d0 = dones_b;
        @(negedge clk);
        mask_b = 5'h1F; start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (ss_b === 5'b00010) found = 1;
        end
        check("to_rho_issued", found, 1);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (err_b === 1'b1) begin n = i; break; end
        end
        check("to_error_latency", n, 18);
        check("to_ready_idle", rdy_b, 1);
        p0 = pulses_b;
        repeat (5) @(negedge clk);
        check("to_no_done", dones_b - d0, 0);
        check("to_no_restart", pulses_b - p0, 0);
        check("to_error_sticky", err_b, 1);
        stuck_b = '0;
        run(1'b1, 5'h1F, 200, n);
        check("to_rerun_latency", n, 62);
        check("to_error_cleared", err_b, 0);

        // Reset in the middle of WAITD of round 7
        @(negedge clk);
        mask_a = 5'h1F; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (ss_a !== 5'd0 && ri_a === 5'd7) found = 1;
        end
        check("mid_reached_round7", found, 1);
        repeat (2) @(negedge clk);
        check("mid_bank_before", bs_a, 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_ready", rdy_a, 1);
        check("mid_roundidx", ri_a, 0);
        check("mid_banksel", bs_a, 0);
        check("mid_stepstart", ss_a, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run(1'b0, 5'h1F, 2000, n);
        check("mid_rerun_latency", n, 722);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
